// File: rtl/trafficlights_display.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// trafficlights_display
//   Drives a 4-digit multiplexed common-anode 7-segment display from the
//   traffic-light controller's countdown value and lane light codes.
//   Digit 3 (leftmost) shows the lane-0 light as a letter. Digits 2..0 show the
//   countdown in decimal, with leading zeros blanked. A sequential double-dabble
//   engine performs the binary-to-BCD conversion. A refresh divider scans the
//   digits on the same clock.
//
// Ports
//   tclk      in   1  system clock
//   rst       in   1  synchronous active-high reset
//   count     in   8  countdown value, unsigned 0..255
//   tf0       in   3  lane-0 light, one-hot {red, green, yellow}
//   tf1       in   3  lane-1 light, same encoding (drives the decimal point)
//   an        out  4  digit enables, active-low, an[3] leftmost
//   seg       out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp        out  1  decimal point, active-low
//   bcd_busy  out  1  high while a conversion is in progress
// -----------------------------------------------------------------------------
module trafficlights_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       tclk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic [2:0] tf0,
  input  logic [2:0] tf1,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       bcd_busy
);

  localparam int             RW       = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0]  REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0]  REF_ONE  = RW'(1);
  localparam logic [RW-1:0]  REF_ZERO = RW'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  cap_r;
  logic [19:0] sr_r;
  logic [19:0] sr_adj_s;
  logic [2:0]  bit_r;
  logic [3:0]  hund_r, tens_r, ones_r;
  logic        busy_r;
  logic [RW-1:0] ref_r;
  logic [1:0]  idx_r;
  logic [3:0]  an_s, an_r;
  logic [6:0]  seg_s, seg_r;
  logic        dp_s, dp_r;

  // Double-dabble correction: a BCD nibble of 5 or more would overflow past 9
  // once doubled, so pre-add 3 before the shift.
  function automatic logic [3:0] adj3(input logic [3:0] n);
    if (n >= 4'd5) begin
      return n + 4'd3;
    end else begin
      return n;
    end
  endfunction

  // Decimal digit to active-low segment pattern.
  function automatic logic [6:0] dec_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Light code to letter. A code that is not one-hot shows a dash.
  function automatic logic [6:0] light_glyph(input logic [2:0] t);
    case (t)
      3'b100:  return 7'h2F;
      3'b010:  return 7'h42;
      3'b001:  return 7'h11;
      default: return 7'h3F;
    endcase
  endfunction

  assign sr_adj_s = {adj3(sr_r[19:16]), adj3(sr_r[15:12]), adj3(sr_r[11:8]), sr_r[7:0]};

  // Conversion FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (count != cap_r) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD:  state_s = SHIFT;
      SHIFT: begin
        if (bit_r == 3'd7) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Conversion state, datapath and display registers. Reset lands in LOAD so
  // that a fresh conversion always follows reset.
  always_ff @(posedge tclk) begin
    if (rst) begin
      state_r <= LOAD;
      cap_r   <= 8'd0;
      sr_r    <= 20'd0;
      bit_r   <= 3'd0;
      hund_r  <= 4'd0;
      tens_r  <= 4'd0;
      ones_r  <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      case (state_r)
        LOAD: begin
          cap_r <= count;
          sr_r  <= {12'd0, count};
          bit_r <= 3'd0;
        end
        SHIFT: begin
          sr_r  <= {sr_adj_s[18:0], 1'b0};
          bit_r <= bit_r + 3'd1;
        end
        DONE: begin
          // Display digits change only here, so a partial result is never shown.
          hund_r <= sr_r[19:16];
          tens_r <= sr_r[15:12];
          ones_r <= sr_r[11:8];
        end
        default: begin
        end
      endcase
    end
  end

  // Refresh divider and digit index.
  always_ff @(posedge tclk) begin
    if (rst) begin
      ref_r <= REF_ZERO;
      idx_r <= 2'd0;
    end else if (ref_r == REF_LAST) begin
      ref_r <= REF_ZERO;
      idx_r <= idx_r + 2'd1;
    end else begin
      ref_r <= ref_r + REF_ONE;
    end
  end

  // Per-slot digit content. The lane codes are used live rather than captured.
  always_comb begin
    an_s  = 4'hF;
    seg_s = 7'h7F;
    dp_s  = 1'b1;
    case (idx_r)
      2'd0: begin
        an_s  = 4'hE;
        seg_s = dec_glyph(ones_r);
      end
      2'd1: begin
        an_s = 4'hD;
        if ((hund_r == 4'd0) && (tens_r == 4'd0)) begin
          seg_s = 7'h7F;
        end else begin
          seg_s = dec_glyph(tens_r);
        end
      end
      2'd2: begin
        an_s = 4'hB;
        if (hund_r == 4'd0) begin
          seg_s = 7'h7F;
        end else begin
          seg_s = dec_glyph(hund_r);
        end
      end
      2'd3: begin
        an_s  = 4'h7;
        seg_s = light_glyph(tf0);
        if (tf1 == 3'b010) begin
          dp_s = 1'b0;
        end else begin
          dp_s = 1'b1;
        end
      end
      default: begin
        an_s  = 4'hF;
        seg_s = 7'h7F;
        dp_s  = 1'b1;
      end
    endcase
  end

  // Registered display drive.
  always_ff @(posedge tclk) begin
    if (rst) begin
      an_r  <= 4'hF;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= dp_s;
    end
  end

  assign an       = an_r;
  assign seg      = seg_r;
  assign dp       = dp_r;
  assign bcd_busy = busy_r;

endmodule

// File: tb/tb_trafficlights_display.sv
`timescale 1ns / 1ps
// Self-checking bench for trafficlights_display with a short refresh period.
module tb_trafficlights_display;

  logic       tclk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic [2:0] tf0;
  logic [2:0] tf1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       bcd_busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
    logic       dp3;
  } disp_t;

  disp_t q[$];
  disp_t shown;
  int    disp_val;

  always #5 tclk = ~tclk;

  trafficlights_display #(.REFRESH_DIV(4)) dut (
    .tclk     (tclk),
    .rst      (rst),
    .count    (count),
    .tf0      (tf0),
    .tf1      (tf1),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .bcd_busy (bcd_busy)
  );

  function automatic logic [6:0] dglyph(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic disp_t model(input int v, input logic [2:0] t0, input logic [2:0] t1);
    disp_t m;
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    m.s0 = dglyph(o);
    m.s1 = (h == 0 && t == 0) ? 7'h7F : dglyph(t);
    m.s2 = (h == 0) ? 7'h7F : dglyph(h);
    m.s3 = (t0 == 3'b100) ? 7'h2F : (t0 == 3'b010) ? 7'h42 : (t0 == 3'b001) ? 7'h11 : 7'h3F;
    m.dp3 = (t1 == 3'b010) ? 1'b0 : 1'b1;
    return m;
  endfunction

  function automatic logic [6:0] eseg(input disp_t e, input int i);
    case (i)
      0: return e.s0;
      1: return e.s1;
      2: return e.s2;
      default: return e.s3;
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'hE: return 0;
      4'hD: return 1;
      4'hB: return 2;
      4'h7: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tclk);
    #1;
  endtask

  // While a conversion runs, the old digits must stay on the display.
  // Optionally changes count at busy-sample chg_at to exercise last-value-wins.
  task automatic watch(input string tag, input disp_t e, input int chg_at,
                       input logic [7:0] chg_v, output int n);
    int sl;
    n = 0;
    while (bcd_busy === 1'b1 && n < 30) begin
      sl = slot_of(an);
      if (sl < 0) begin
        chk({tag, "_an_onehot"}, {28'd0, an}, 32'hE);
      end else begin
        chk({tag, "_hold_seg"}, {25'd0, seg}, {25'd0, eseg(e, sl)});
      end
      if (chg_at > 0 && n == chg_at) begin
        count = chg_v;
        q.push_back(model(chg_v, tf0, tf1));
      end
      n++;
      step();
    end
  endtask

  task automatic check_scan(input string tag, input disp_t e);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] want;
      int w;
      want = ~(4'b0001 << i);
      w = 0;
      step();
      while (an !== want && w < 20) begin
        step();
        w++;
      end
      chk({tag, "_an"}, {28'd0, an}, {28'd0, want});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, eseg(e, i)});
      chk({tag, "_dp"}, {31'd0, dp}, {31'd0, (i == 3) ? e.dp3 : 1'b1});
    end
  endtask

  task automatic wait_start(input string tag);
    int w;
    w = 0;
    step();
    while (bcd_busy !== 1'b1 && w < 5) begin
      step();
      w++;
    end
    chk({tag, "_start"}, {31'd0, bcd_busy}, 32'd1);
  endtask

  // One conversion from IDLE; chg_at > 0 plants a mid-conversion count change.
  task automatic conv(input string tag, input logic [7:0] v, input int chg_at, input logic [7:0] chg_v);
    int n;
    count = v;
    q.push_back(model(v, tf0, tf1));
    wait_start(tag);
    watch(tag, model(disp_val, tf0, tf1), chg_at, chg_v, n);
    chk({tag, "_lat"}, n, 32'd10);
    shown = q.pop_front();
    disp_val = v;
    if (chg_at > 0) begin
      wait_start({tag, "_second"});
      watch({tag, "_second"}, shown, 0, 8'd0, n);
      chk({tag, "_second_lat"}, n, 32'd10);
      shown = q.pop_front();
      disp_val = chg_v;
    end
    check_scan(tag, shown);
  endtask

  // Forced conversion following reset release; display registers start at 0.
  task automatic post_reset(input string tag);
    int n;
    q.push_back(model(count, tf0, tf1));
    disp_val = 0;
    step();
    chk({tag, "_busy_first"}, {31'd0, bcd_busy}, 32'd1);
    watch(tag, model(0, tf0, tf1), 0, 8'd0, n);
    chk({tag, "_lat_from_release"}, n + 1, 32'd10);
    shown = q.pop_front();
    disp_val = count;
    check_scan(tag, shown);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Test 1: reset, then forced conversion of 45
    rst = 1'b1;
    count = 8'd45;
    tf0 = 3'b010;
    tf1 = 3'b100;
    disp_val = 0;
    step();
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_busy", {31'd0, bcd_busy}, 32'd0);
    step();
    rst = 1'b0;
    post_reset("t1_45");

    // Test 2: 255 with yellow
    tf0 = 3'b001;
    conv("t2_255", 8'd255, 0, 8'd0);

    // Test 3: blanking patterns
    conv("t3_45", 8'd45, 0, 8'd0);
    conv("t3_0", 8'd0, 0, 8'd0);
    conv("t3_5", 8'd5, 0, 8'd0);
    conv("t3_100", 8'd100, 0, 8'd0);

    // Test 4: count changes to 7 during the third SHIFT cycle of 25
    conv("t4_25_to_7", 8'd25, 3, 8'd7);

    // Test 5: lane glyphs and decimal point
    tf0 = 3'b011;
    check_scan("t5_tf0_011", model(disp_val, tf0, tf1));
    tf0 = 3'b000;
    check_scan("t5_tf0_000", model(disp_val, tf0, tf1));
    tf0 = 3'b100;
    tf1 = 3'b010;
    check_scan("t5_dp", model(disp_val, tf0, tf1));

    // Test 6: reset during SHIFT aborts; forced conversion follows
    count = 8'd200;
    step();
    step();
    step();
    chk("t6_busy_before_rst", {31'd0, bcd_busy}, 32'd1);
    rst = 1'b1;
    step();
    chk("t6_rst_an", {28'd0, an}, 32'hF);
    chk("t6_rst_seg", {25'd0, seg}, 32'h7F);
    chk("t6_rst_dp", {31'd0, dp}, 32'd1);
    chk("t6_rst_busy", {31'd0, bcd_busy}, 32'd0);
    rst = 1'b0;
    post_reset("t6_200");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trafficlights_display.md
Name: trafficlights_display

Overview:
- Downstream consumer of the traffic-light controller.
- Takes the 8-bit countdown and the lane-0/lane-1 light codes and drives a 4-digit multiplexed common-anode 7-segment display.
- Digit 3 shows the lane-0 light as a letter; digits 2..0 show the countdown in decimal with leading-zero blanking.
- Binary-to-BCD conversion is a sequential double-dabble engine; digit scanning runs off a refresh divider on the same clock.

Parameters:
REFRESH_DIV, 100000, tclk cycles per digit slot (100 MHz gives 1 kHz per digit); legal range ≥2.

Ports:
- tclk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- count  in  8  countdown value from controller, unsigned 0..255
- tf0  in  3  lane-0 light, one-hot: [2] red, [1] green, [0] yellow
- tf1  in  3  lane-1 light, same encoding
- an  out  4  digit enables, active-low, an[3] leftmost
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- bcd_busy  out  1  high while a conversion is in progress

Behaviour:
Reset (rst high at a tclk edge):
- an=4'hF, seg=7'h7F, dp=1, bcd_busy=0.
- BCD display registers = 0; captured count = 0; refresh counter = 0; digit index = 0.
- Conversion FSM enters LOAD, so one conversion is always forced on the first cycle after reset.
- Reset asserted mid-conversion aborts it; the partial result is discarded.

Conversion FSM (IDLE, LOAD, SHIFT, DONE):
- IDLE: when count != captured count, go to LOAD.
- LOAD: captured count <= count; 20-bit shift register <= {12'b0, count}; bit counter = 0; bcd_busy=1.
- SHIFT: 8 cycles. Each cycle, add 3 to any BCD nibble ≥5, then shift left 1. After the 8th cycle go to DONE.
- DONE: copy hundreds/tens/ones nibbles to the display registers; bcd_busy=0; return to IDLE.
- Latency: 10 tclk from leaving IDLE to updated display registers. The display registers hold their old value throughout a conversion, so a partial result is never shown.
- count changing during a conversion is ignored. On return to IDLE the mismatch is seen and a new conversion starts, so the last value always wins.
- Result check: hundreds ≤2; tens/ones ≤9; 255 yields 2/5/5.

Scan:
- Refresh counter runs 0..REFRESH_DIV-1 and wraps.
- At the terminal count, digit index increments (0→1→2→3→0).
- an, seg and dp are registered and change 1 tclk after the index changes. Exactly one an bit is low outside reset.

Digit content:
- idx0: ones digit, always shown.
- idx1: tens digit; blank (7'h7F) if hundreds=0 and tens=0.
- idx2: hundreds digit; blank if 0.
- idx3: glyph for tf0: red 'r'=7'h2F, green 'G'=7'h42, yellow 'Y'=7'h11. Any non-one-hot code (including 000) shows '-'=7'h3F.
- Decimal glyphs 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
- dp=0 only during the idx3 slot and only when tf1==3'b010; otherwise 1.
- tf0/tf1 are sampled live (not captured) when the output registers load.

Test Plan:
1. REFRESH_DIV=4, rst 2 cycles, then count=45, tf0=010, tf1=100. Expect: bcd_busy high 10 cycles after reset release, then low. Slots show an=E seg=12; an=D seg=19; an=B seg=7F; an=7 seg=42 dp=1.
2. count=255, tf0=001. Expect after 10 cycles: digits 2/5/5 (24,12,12); digit3 seg=11.
3. count 45→0: ones=40, tens and hundreds blank. Then count=5: ones=12 with the other two digits blank. Then count=100: hundreds=79, tens=40, ones=40.
4. Change count 25→7 at cycle 3 of SHIFT. Expect: display shows 25 first, then a second conversion starts immediately and the display shows 7, with no intermediate value.
5. tf0=011 → digit3 seg=3F. tf0=000 → 3F. tf1=010 → dp=0 only while an=7.
6. Assert rst during SHIFT. Expect: an=F, seg=7F, bcd_busy=0 next edge. After release, a forced conversion of the current count completes in 10 cycles.
